// File: rtl/sm_colour_pkg.sv
// Shared colour codes, debounce FSM states and the colour type used by the
// sm_colour_confirm design and its event FIFO.
`timescale 1ns/1ps
package sm_colour_pkg;

    typedef logic [1:0] colour_t;

    localparam colour_t COL_WHITE = 2'd0;
    localparam colour_t COL_RED   = 2'd1;
    localparam colour_t COL_GREEN = 2'd2;
    localparam colour_t COL_BLUE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAND = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/sm_colour_confirm_if.sv
// Confirmed-mark event stream toward the reporting stage (valid/ready).
`timescale 1ns/1ps
interface sm_colour_confirm_if;
    import sm_colour_pkg::*;

    logic    evt_valid;
    colour_t evt_colour;
    logic    evt_ready;

    modport master (output evt_valid, output evt_colour, input evt_ready);
    modport slave  (input evt_valid, input evt_colour, output evt_ready);
endinterface

// File: rtl/sm_event_fifo.sv
// First-word-fall-through event queue; a push into a full queue is accepted
// only when a pop frees a slot in the same cycle.
`timescale 1ns/1ps
module sm_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_take;
    logic             w_pop_take;

    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == (AW+1)'(DEPTH));
    assign w_pop_take  = i_pop & ~o_empty;
    assign w_push_take = i_push & (~o_full | w_pop_take);
    // Head is masked while empty so the output reads 0 rather than stale data.
    assign o_dout      = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk_50) begin
        if (w_push_take) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_take) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_take) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_take, w_pop_take})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sm_colour_confirm.sv
// Debounces classifier frames into one event per physical colour mark, queues
// events and keeps saturating per-colour tallies. Optional LED indicator is
// enabled with the macro SM_COLOUR_CONFIRM_LED_EN.
`timescale 1ns/1ps
module sm_colour_confirm
    import sm_colour_pkg::*;
#(
    parameter int CONFIRM_FRAMES = 3,
    parameter int RELEASE_FRAMES = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int CNT_W          = 8
`ifdef SM_COLOUR_CONFIRM_LED_EN
    ,
    parameter int LED_HOLD       = 25_000_000
`endif
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic              frame_valid,
    input  colour_t           colour,
    input  logic              detected,
    sm_colour_confirm_if.master evt,
    output logic [CNT_W-1:0]  cnt_red,
    output logic [CNT_W-1:0]  cnt_green,
    output logic [CNT_W-1:0]  cnt_blue,
    output logic              overflow,
    output logic              busy
`ifdef SM_COLOUR_CONFIRM_LED_EN
    ,
    output logic              led_r,
    output logic              led_g,
    output logic              led_b
`endif
);
    localparam logic [3:0] CONF_N = 4'(CONFIRM_FRAMES);
    localparam logic [3:0] REL_N  = 4'(RELEASE_FRAMES);

    state_t     r_state, w_state_next;
    logic [3:0] r_match, w_match_next;
    logic [3:0] r_release, w_release_next;
    colour_t    r_cand, w_cand_next;
    logic       w_hit;
    logic       w_confirm;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       r_overflow;

    assign w_hit = frame_valid & detected & (colour != COL_WHITE);

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_match   <= '0;
            r_release <= '0;
            r_cand    <= COL_WHITE;
        end else begin
            r_state   <= w_state_next;
            r_match   <= w_match_next;
            r_release <= w_release_next;
            r_cand    <= w_cand_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_match_next   = r_match;
        w_release_next = r_release;
        w_cand_next    = r_cand;
        w_confirm      = 1'b0;
        if (frame_valid) begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        w_cand_next  = colour;
                        w_match_next = 4'd1;
                        if (CONF_N == 4'd1) begin
                            w_confirm      = 1'b1;
                            w_match_next   = '0;
                            w_release_next = '0;
                            w_state_next   = HOLD;
                        end else begin
                            w_state_next = CAND;
                        end
                    end
                end
                CAND: begin
                    if (w_hit && colour == r_cand) begin
                        if (r_match + 4'd1 >= CONF_N) begin
                            w_confirm      = 1'b1;
                            w_match_next   = '0;
                            w_release_next = '0;
                            w_state_next   = HOLD;
                        end else begin
                            w_match_next = r_match + 4'd1;
                        end
                    end else if (w_hit) begin
                        w_cand_next  = colour;
                        w_match_next = 4'd1;
                    end else begin
                        w_match_next = '0;
                        w_state_next = IDLE;
                    end
                end
                HOLD: begin
                    // Any hit while holding means the same mark is still in view.
                    if (w_hit) begin
                        w_release_next = '0;
                    end else if (r_release + 4'd1 >= REL_N) begin
                        w_release_next = '0;
                        w_state_next   = IDLE;
                    end else begin
                        w_release_next = r_release + 4'd1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // The confirming frame's colour always equals the candidate, so push it directly.
    sm_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(colour_t))
    ) u_fifo (
        .clk_50  (clk_50),
        .rst_n   (rst_n),
        .i_push  (w_confirm),
        .i_din   (colour),
        .i_pop   (evt.evt_ready),
        .o_dout  (evt.evt_colour),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign evt.evt_valid = ~w_fifo_empty;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_confirm && w_fifo_full && !evt.evt_ready) begin
            r_overflow <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            localparam colour_t MY_COL = colour_t'(gi + 1);
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge clk_50 or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_confirm && colour == MY_COL && r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    assign cnt_red   = g_cnt[0].r_cnt;
    assign cnt_green = g_cnt[1].r_cnt;
    assign cnt_blue  = g_cnt[2].r_cnt;
    assign overflow  = r_overflow;
    assign busy      = (r_state != IDLE);

`ifdef SM_COLOUR_CONFIRM_LED_EN
    localparam int TW = $clog2(LED_HOLD + 1);

    logic [2:0]    r_led;
    logic [TW-1:0] r_led_timer;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_led       <= '0;
            r_led_timer <= '0;
        end else if (w_confirm) begin
            r_led       <= 3'b001 << (colour - 2'd1);
            r_led_timer <= TW'(LED_HOLD);
        end else if (r_led_timer != '0) begin
            r_led_timer <= r_led_timer - 1'b1;
            if (r_led_timer == TW'(1)) begin
                r_led <= '0;
            end
        end
    end

    assign led_r = r_led[0];
    assign led_g = r_led[1];
    assign led_b = r_led[2];
`endif

endmodule

// File: tb/tb_sm_colour_confirm.sv
// Directed bench for sm_colour_confirm with default parameters (3/2/4/8).
`timescale 1ns/1ps
module tb_sm_colour_confirm;
    import sm_colour_pkg::*;

    logic       clk_50 = 1'b0;
    logic       rst_n  = 1'b0;
    logic       frame_valid = 1'b0;
    colour_t    colour = 2'd0;
    logic       detected = 1'b0;
    logic [7:0] cnt_red, cnt_green, cnt_blue;
    logic       overflow, busy;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] q[$];

    sm_colour_confirm_if evt_if();

    sm_colour_confirm #(
        .CONFIRM_FRAMES (3),
        .RELEASE_FRAMES (2),
        .FIFO_DEPTH     (4),
        .CNT_W          (8)
    ) dut (
        .clk_50      (clk_50),
        .rst_n       (rst_n),
        .frame_valid (frame_valid),
        .colour      (colour),
        .detected    (detected),
        .evt         (evt_if),
        .cnt_red     (cnt_red),
        .cnt_green   (cnt_green),
        .cnt_blue    (cnt_blue),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #10 clk_50 = ~clk_50;

    // Record every accepted event.
    always @(posedge clk_50) begin
        if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
            q.push_back(evt_if.evt_colour);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic frame(input logic [1:0] c, input logic d);
        @(negedge clk_50);
        frame_valid = 1'b1;
        colour      = c;
        detected    = d;
        @(negedge clk_50);
        frame_valid = 1'b0;
        colour      = 2'd0;
        detected    = 1'b0;
    endtask

    task automatic mark(input logic [1:0] c);
        repeat (3) frame(c, 1'b1);
        repeat (2) frame(2'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_50);
        rst_n = 1'b0;
        frame_valid = 1'b0;
        evt_if.evt_ready = 1'b1;
        repeat (2) @(negedge clk_50);
        rst_n = 1'b1;
        q.delete();
    endtask

    initial begin
        evt_if.evt_ready = 1'b1;
        @(negedge clk_50);
        chk("rst_valid", 32'(evt_if.evt_valid), 0);
        chk("rst_colour", 32'(evt_if.evt_colour), 0);
        chk("rst_cnts", {8'd0, cnt_red, cnt_green, cnt_blue}, 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk_50);
        rst_n = 1'b1;

        // 3 red hits
        frame(2'd1, 1'b1);
        frame(2'd1, 1'b1);
        chk("t1_busy_cand", 32'(busy), 1);
        @(negedge clk_50);
        frame_valid = 1'b1; colour = 2'd1; detected = 1'b1;
        #5 chk("t1_pre_valid", 32'(evt_if.evt_valid), 0);
        @(negedge clk_50);
        frame_valid = 1'b0; detected = 1'b0; colour = 2'd0;
        chk("t1_valid", 32'(evt_if.evt_valid), 1);
        chk("t1_colour", 32'(evt_if.evt_colour), 1);
        chk("t1_cnt_red", 32'(cnt_red), 1);
        frame(2'd0, 1'b0);
        chk("t1_busy_hold", 32'(busy), 1);
        chk("t1_popped", 32'(evt_if.evt_valid), 0);
        frame(2'd0, 1'b0);
        chk("t1_busy_idle", 32'(busy), 0);
        chk("t1_nevents", 32'(q.size()), 1);

        // red, red, green x3
        do_reset();
        frame(2'd1, 1'b1); frame(2'd1, 1'b1);
        frame(2'd2, 1'b1); frame(2'd2, 1'b1); frame(2'd2, 1'b1);
        chk("t2_colour", 32'(evt_if.evt_colour), 2);
        chk("t2_cnt_red", 32'(cnt_red), 0);
        chk("t2_cnt_green", 32'(cnt_green), 1);
        repeat (2) frame(2'd0, 1'b0);
        chk("t2_nevents", 32'(q.size()), 1);

        // blue, blue, miss, blue x3
        do_reset();
        frame(2'd3, 1'b1); frame(2'd3, 1'b1); frame(2'd0, 1'b0);
        frame(2'd3, 1'b1); frame(2'd3, 1'b1);
        chk("t3_no_evt", 32'(evt_if.evt_valid), 0);
        frame(2'd3, 1'b1);
        chk("t3_valid", 32'(evt_if.evt_valid), 1);
        chk("t3_colour", 32'(evt_if.evt_colour), 3);
        chk("t3_cnt_blue", 32'(cnt_blue), 1);
        repeat (2) frame(2'd0, 1'b0);
        chk("t3_nevents", 32'(q.size()), 1);

        // Hits during HOLD do not produce events
        do_reset();
        repeat (3) frame(2'd3, 1'b1);
        repeat (5) frame(2'd1, 1'b1);
        chk("t4_hold_busy", 32'(busy), 1);
        chk("t4_hold_cnt_red", 32'(cnt_red), 0);
        repeat (2) frame(2'd0, 1'b0);
        chk("t4_idle", 32'(busy), 0);
        repeat (3) frame(2'd1, 1'b1);
        @(negedge clk_50);
        chk("t4_nevents", 32'(q.size()), 2);
        if (q.size() == 2) begin
            chk("t4_ev0", 32'(q[0]), 3);
            chk("t4_ev1", 32'(q[1]), 1);
        end
        chk("t4_cnt_red", 32'(cnt_red), 1);
        chk("t4_cnt_blue", 32'(cnt_blue), 1);

        // Overflow with consumer stalled
        do_reset();
        evt_if.evt_ready = 1'b0;
        mark(2'd1);
        chk("t5_first", 32'(evt_if.evt_colour), 1);
        mark(2'd2); mark(2'd3); mark(2'd1);
        chk("t5_ovf_full", 32'(overflow), 0);
        mark(2'd2);
        chk("t5_ovf", 32'(overflow), 1);
        chk("t5_valid", 32'(evt_if.evt_valid), 1);
        chk("t5_head", 32'(evt_if.evt_colour), 1);
        chk("t5_cnts", {8'd0, cnt_red, cnt_green, cnt_blue}, 32'h00020201);
        evt_if.evt_ready = 1'b1;
        repeat (6) @(negedge clk_50);
        evt_if.evt_ready = 1'b0;
        chk("t5_drained", 32'(q.size()), 4);
        if (q.size() == 4) begin
            chk("t5_order", {24'd0, q[0], q[1], q[2], q[3]}, 32'b01_10_11_01);
        end
        chk("t5_empty", 32'(evt_if.evt_valid), 0);

        // Push into full FIFO with a same-cycle pop
        do_reset();
        evt_if.evt_ready = 1'b0;
        mark(2'd1); mark(2'd2); mark(2'd3); mark(2'd1);
        frame(2'd2, 1'b1); frame(2'd2, 1'b1);
        @(negedge clk_50);
        frame_valid = 1'b1; colour = 2'd2; detected = 1'b1;
        evt_if.evt_ready = 1'b1;
        @(negedge clk_50);
        frame_valid = 1'b0; colour = 2'd0; detected = 1'b0;
        evt_if.evt_ready = 1'b0;
        chk("t6_ovf", 32'(overflow), 0);
        chk("t6_popped", 32'(q.size()), 1);
        chk("t6_head", 32'(evt_if.evt_colour), 2);
        chk("t6_cnt_green", 32'(cnt_green), 2);
        repeat (2) frame(2'd0, 1'b0);
        q.delete();
        evt_if.evt_ready = 1'b1;
        repeat (6) @(negedge clk_50);
        chk("t6_drained", 32'(q.size()), 4);
        if (q.size() == 4) begin
            chk("t6_order", {24'd0, q[0], q[1], q[2], q[3]}, 32'b10_11_01_10);
        end

        // Asynchronous reset mid-CAND
        do_reset();
        evt_if.evt_ready = 1'b0;
        mark(2'd3);
        frame(2'd1, 1'b1); frame(2'd1, 1'b1);
        chk("t7_busy", 32'(busy), 1);
        chk("t7_queued", 32'(evt_if.evt_valid), 1);
        @(negedge clk_50);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_outs", {26'd0, evt_if.evt_valid, evt_if.evt_colour, overflow, busy, 1'b0}, 0);
        chk("t7_rst_cnts", {8'd0, cnt_red, cnt_green, cnt_blue}, 0);
        @(negedge clk_50);
        rst_n = 1'b1;
        evt_if.evt_ready = 1'b0;
        frame(2'd1, 1'b1); frame(2'd1, 1'b1);
        chk("t7_partial", 32'(evt_if.evt_valid), 0);
        frame(2'd1, 1'b1);
        chk("t7_evt", 32'(evt_if.evt_colour), 1);
        chk("t7_cnt", {8'd0, cnt_red, cnt_green, cnt_blue}, 32'h00010000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
